blackparrot_fpga_host_nbf_axi_writer: RTL and testbench

Consumes the 32b NBF word stream from the host write-CSR path (CSR 'h0), reassembles 5-word NBF packets, and issues single-beat AXI4 writes into BlackParrot's I/O-in port. Fence and finish packets stall the stream until all outstanding writes have been acknowledged. The block sits between the AXI-Lite write-to-FIFO converter and the m_axi_* master port of the FPGA host.

---
 rtl/blackparrot_fpga_host_pkg.sv | 31 +++
 rtl/blackparrot_fpga_host_nbf_wstrb_gen.sv | 20 ++
 rtl/bsg_counter_up_down.sv | 24 ++
 rtl/blackparrot_fpga_host_nbf_axi_writer.sv | 222 ++++++++++++++++++++++
 tb/tb_blackparrot_fpga_host_nbf_axi_writer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared NBF/AXI definitions for the BlackParrot FPGA host.
package blackparrot_fpga_host_pkg;

    localparam int unsigned NBF_WORDS  = 5;
    localparam int unsigned NBF_WORD_W = 32;
    localparam int unsigned NBF_ADDR_W = 64;
    localparam int unsigned NBF_DATA_W = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

    typedef enum logic [7:0] {
        NBF_WRITE1 = 8'h00,
        NBF_WRITE2 = 8'h01,
        NBF_WRITE4 = 8'h02,
        NBF_WRITE8 = 8'h03,
        NBF_FENCE  = 8'hFE,
        NBF_FINISH = 8'hFF
    } nbf_opcode_e;

    typedef struct packed {
        logic [7:0]            opcode;
        logic [NBF_ADDR_W-1:0] addr;
        logic [NBF_DATA_W-1:0] data;
    } nbf_pkt_s;

    function automatic logic nbf_is_write(logic [7:0] opcode);
        return opcode[7:2] == 6'd0;
    endfunction

endpackage

// File: rtl/blackparrot_fpga_host_nbf_wstrb_gen.sv
// Size/offset to byte strobe and lane-shifted write data.
module blackparrot_fpga_host_nbf_wstrb_gen (
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic [63:0] data,
    output logic [7:0]  wstrb_c,
    output logic [63:0] wdata_c
);

    logic [3:0]  nbytes;
    logic [15:0] mask;

    always_comb begin
        nbytes  = 4'(4'd1 << size);
        mask    = (16'd1 << nbytes) - 16'd1;
        wstrb_c = 8'(mask << offset);
        wdata_c = data << {offset, 3'b000};
    end

endmodule

// File: rtl/bsg_counter_up_down.sv
// Up/down counter; the caller keeps it within [0, max_val_p].
module bsg_counter_up_down #(
    parameter int unsigned max_val_p  = 8,
    parameter int unsigned init_val_p = 0,
    parameter int unsigned max_step_p = 1,
    localparam int unsigned PTR_W  = $clog2(max_val_p + 1),
    localparam int unsigned STEP_W = $clog2(max_step_p + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [STEP_W-1:0] up_i,
    input  logic [STEP_W-1:0] down_i,
    output logic [PTR_W-1:0]  count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= PTR_W'(init_val_p);
        end else begin
            count_o <= count_o - PTR_W'(down_i) + PTR_W'(up_i);
        end
    end

endmodule

// File: rtl/blackparrot_fpga_host_nbf_axi_writer.sv
// NBF word stream to single-beat AXI4 writes, with fence/finish draining.
// Optional: BLACKPARROT_FPGA_HOST_NBF_BRESP_CHECK_EN enables sticky bresp error tracking.
module blackparrot_fpga_host_nbf_axi_writer
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int unsigned M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned M_AXI_DATA_WIDTH = 64,
    parameter int unsigned M_AXI_ID_WIDTH   = 4,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,

    input  logic                          nbf_v_i,
    output logic                          nbf_ready_and_o,
    input  logic [NBF_WORD_W-1:0]         nbf_data_i,

    output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awqos,
    output logic [3:0]                    m_axi_awregion,

    output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic                          m_axi_wlast,
    output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,

    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,

    output logic                          done_o,
    output logic                          bresp_err_o
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned STRB_W = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_HOLD,
        S_ISSUE,
        S_FENCE,
        S_DONE
    } state_e;

    state_e               state_q, state_n;
    logic [IDX_W-1:0]     word_idx_q;
    nbf_pkt_s             pkt_q;
    logic [63:0]          wdata_q;
    logic [7:0]           wstrb_q;
    logic                 awvalid_q, wvalid_q, ready_q, bready_q, done_q;
    logic [CNT_W-1:0]     count;
    logic [7:0]           gen_wstrb;
    logic [63:0]          gen_wdata;
    logic                 nbf_fire, last_word, aw_fire, w_fire, b_fire;
    logic                 aw_done, w_done, issue_done, cnt_down, room, issue_start;
    logic                 done_block_c;
    logic                 unused_inputs;

    assign nbf_fire   = nbf_v_i & ready_q;
    assign last_word  = nbf_fire & (word_idx_q == IDX_W'(NBF_WORDS - 1));
    assign aw_fire    = awvalid_q & m_axi_awready;
    assign w_fire     = wvalid_q & m_axi_wready;
    assign b_fire     = m_axi_bvalid & bready_q;
    assign aw_done    = aw_fire | ~awvalid_q;
    assign w_done     = w_fire | ~wvalid_q;
    assign issue_done = (state_q == S_ISSUE) & aw_done & w_done;
    // A B response arriving at zero outstanding is dropped rather than wrapping.
    assign cnt_down   = b_fire & (count != '0);
    assign room       = (count != CNT_W'(MAX_OUTSTANDING)) | cnt_down;

    blackparrot_fpga_host_nbf_wstrb_gen u_wstrb_gen (
        .size    (pkt_q.opcode[1:0]),
        .offset  (pkt_q.addr[2:0]),
        .data    ({nbf_data_i, pkt_q.data[31:0]}),
        .wstrb_c (gen_wstrb),
        .wdata_c (gen_wdata)
    );

    bsg_counter_up_down #(
        .max_val_p  (MAX_OUTSTANDING),
        .init_val_p (0),
        .max_step_p (1)
    ) u_outstanding (
        .clk_i   (m_axi_aclk),
        .reset_i (m_axi_areset),
        .up_i    (issue_done),
        .down_i  (cnt_down),
        .count_o (count)
    );

    // Next-state decode
    always_comb begin
        state_n     = state_q;
        issue_start = 1'b0;
        unique case (state_q)
            S_COLLECT: begin
                if (last_word) begin
                    if (nbf_is_write(pkt_q.opcode)) begin
                        if (room) begin
                            state_n     = S_ISSUE;
                            issue_start = 1'b1;
                        end else begin
                            state_n = S_HOLD;
                        end
                    end else if ((pkt_q.opcode == 8'(NBF_FENCE)) || (pkt_q.opcode == 8'(NBF_FINISH))) begin
                        state_n = S_FENCE;
                    end
                end
            end
            S_HOLD: begin
                if (room) begin
                    state_n     = S_ISSUE;
                    issue_start = 1'b1;
                end
            end
            S_ISSUE: begin
                if (aw_done && w_done) state_n = S_COLLECT;
            end
            S_FENCE: begin
                if (count == '0) state_n = (pkt_q.opcode == 8'(NBF_FINISH)) ? S_DONE : S_COLLECT;
            end
            S_DONE: state_n = S_DONE;
            default: state_n = S_COLLECT;
        endcase
    end

    // Control state
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q    <= S_COLLECT;
            word_idx_q <= '0;
            ready_q    <= 1'b0;
            bready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            ready_q  <= (state_n == S_COLLECT);
            bready_q <= 1'b1;
            if (nbf_fire) word_idx_q <= last_word ? '0 : word_idx_q + IDX_W'(1);
            if (issue_start)  awvalid_q <= 1'b1;
            else if (aw_fire) awvalid_q <= 1'b0;
            if (issue_start)  wvalid_q <= 1'b1;
            else if (w_fire)  wvalid_q <= 1'b0;
            if ((state_q == S_FENCE) && (state_n == S_DONE) && !done_block_c) done_q <= 1'b1;
        end
    end

    // Packet payload; needs no reset since it is only consumed after a full packet
    always_ff @(posedge m_axi_aclk) begin
        if (nbf_fire) begin
            unique case (word_idx_q)
                3'd0:    pkt_q.opcode       <= nbf_data_i[7:0];
                3'd1:    pkt_q.addr[31:0]   <= nbf_data_i;
                3'd2:    pkt_q.addr[63:32]  <= nbf_data_i;
                3'd3:    pkt_q.data[31:0]   <= nbf_data_i;
                3'd4:    pkt_q.data[63:32]  <= nbf_data_i;
                default: ;
            endcase
        end
        if (last_word) begin
            wdata_q <= gen_wdata;
            wstrb_q <= gen_wstrb;
        end
    end

`ifdef BLACKPARROT_FPGA_HOST_NBF_BRESP_CHECK_EN
    logic err_q;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            err_q <= 1'b0;
        end else if (b_fire && (m_axi_bresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign bresp_err_o   = err_q;
    assign done_block_c  = err_q;
    assign unused_inputs = ^{m_axi_bid, pkt_q.data[63:32]};
`else
    assign bresp_err_o   = 1'b0;
    assign done_block_c  = 1'b0;
    assign unused_inputs = ^{m_axi_bid, m_axi_bresp, pkt_q.data[63:32]};
`endif

    assign nbf_ready_and_o = ready_q;
    assign done_o          = done_q;
    assign m_axi_bready    = bready_q;

    assign m_axi_awaddr   = M_AXI_ADDR_WIDTH'(pkt_q.addr);
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_awid     = '0;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = AXI_CACHE_BUF_MOD;
    assign m_axi_awprot   = '0;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = {1'b0, pkt_q.opcode[1:0]};
    assign m_axi_awburst  = AXI_BURST_INCR;
    assign m_axi_awqos    = '0;
    assign m_axi_awregion = '0;

    assign m_axi_wdata  = M_AXI_DATA_WIDTH'(wdata_q);
    assign m_axi_wvalid = wvalid_q;
    assign m_axi_wlast  = 1'b1;
    assign m_axi_wstrb  = STRB_W'(wstrb_q);

endmodule

// File: tb/tb_blackparrot_fpga_host_nbf_axi_writer.sv
// Scoreboard bench for the NBF AXI writer; one process drives, monitors and checks.
module tb_blackparrot_fpga_host_nbf_axi_writer;

    localparam int unsigned MAX_OUT = 2;

`ifdef BLACKPARROT_FPGA_HOST_NBF_BRESP_CHECK_EN
    localparam logic EXP_ERR  = 1'b1;
    localparam logic EXP_DONE = 1'b0;
`else
    localparam logic EXP_ERR  = 1'b0;
    localparam logic EXP_DONE = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        areset;
    logic        nbf_v, nbf_ready;
    logic [31:0] nbf_data;
    logic [63:0] awaddr;
    logic        awvalid, awready, awlock;
    logic [3:0]  awid, awcache, awqos, awregion;
    logic [2:0]  awprot, awsize;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [63:0] wdata;
    logic        wvalid, wready, wlast;
    logic [7:0]  wstrb;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        done, err;

    always #5 clk = ~clk;

    blackparrot_fpga_host_nbf_axi_writer #(
        .M_AXI_ADDR_WIDTH (64),
        .M_AXI_DATA_WIDTH (64),
        .M_AXI_ID_WIDTH   (4),
        .MAX_OUTSTANDING  (MAX_OUT)
    ) dut (
        .m_axi_aclk      (clk),
        .m_axi_areset    (areset),
        .nbf_v_i         (nbf_v),
        .nbf_ready_and_o (nbf_ready),
        .nbf_data_i      (nbf_data),
        .m_axi_awaddr    (awaddr),
        .m_axi_awvalid   (awvalid),
        .m_axi_awready   (awready),
        .m_axi_awid      (awid),
        .m_axi_awlock    (awlock),
        .m_axi_awcache   (awcache),
        .m_axi_awprot    (awprot),
        .m_axi_awlen     (awlen),
        .m_axi_awsize    (awsize),
        .m_axi_awburst   (awburst),
        .m_axi_awqos     (awqos),
        .m_axi_awregion  (awregion),
        .m_axi_wdata     (wdata),
        .m_axi_wvalid    (wvalid),
        .m_axi_wready    (wready),
        .m_axi_wlast     (wlast),
        .m_axi_wstrb     (wstrb),
        .m_axi_bvalid    (bvalid),
        .m_axi_bready    (bready),
        .m_axi_bid       (bid),
        .m_axi_bresp     (bresp),
        .done_o          (done),
        .bresp_err_o     (err)
    );

    typedef struct { logic [63:0] addr; logic [2:0] size; } aw_exp_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; } w_exp_t;

    aw_exp_t     exp_aw[$];
    w_exp_t      exp_w[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          aw_cnt   = 0;
    int          w_cnt    = 0;
    int          b_cnt    = 0;
    int          aw_stall = 0;
    logic        b_hold   = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic        nbf_acc  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: sample at negedge, then update the slave model just after posedge
    task automatic tick();
        logic    b_fire;
        aw_exp_t ea;
        w_exp_t  ew;
        @(negedge clk);
        nbf_acc = nbf_v && nbf_ready;
        b_fire  = bvalid && bready;
        if (awvalid === 1'b1 && awready) begin
            aw_cnt++;
            check("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
            if (exp_aw.size() != 0) begin
                ea = exp_aw.pop_front();
                check("awaddr", awaddr, ea.addr);
                check("awsize", 64'(awsize), 64'(ea.size));
                check("aw_fixed", 64'({awid, awlock, awcache, awprot, awlen, awburst, awqos, awregion}),
                      64'({4'd0, 1'b0, 4'b0011, 3'd0, 8'd0, 2'b01, 4'd0, 4'd0}));
            end
        end
        if (wvalid === 1'b1 && wready) begin
            w_cnt++;
            check("w_expected", 64'(exp_w.size() != 0), 64'd1);
            if (exp_w.size() != 0) begin
                ew = exp_w.pop_front();
                check("wdata", wdata, ew.data);
                check("wlast_wstrb", 64'({wlast, wstrb}), 64'({1'b1, ew.strb}));
            end
        end
        @(posedge clk);
        #1;
        if (b_fire) begin
            bvalid = 1'b0;
            b_cnt++;
        end
        if (!bvalid && !b_hold && aw_cnt > b_cnt) begin
            bvalid = 1'b1;
            bresp  = b_resp_cfg;
        end
        awready = (aw_stall == 0);
        if (aw_stall > 0) aw_stall--;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic accepted = 1'b0;
        nbf_v    = 1'b1;
        nbf_data = w;
        for (int i = 0; i < 200 && !accepted; i++) begin
            tick();
            accepted = nbf_acc;
        end
        if (!accepted) check("nbf_accept", 64'(accepted), 64'd1);
        nbf_v = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [63:0] addr, input logic [63:0] data);
        aw_exp_t    ea;
        w_exp_t     ew;
        int         nb, off;
        if (op[7:2] == 6'd0) begin
            nb  = 1 << op[1:0];
            off = int'(addr[2:0]);
            ew.strb = 8'd0;
            for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) ew.strb[i] = 1'b1;
            ew.data = data << (8 * off);
            ea.addr = addr;
            ea.size = {1'b0, op[1:0]};
            exp_aw.push_back(ea);
            exp_w.push_back(ew);
        end
        send_word({24'd0, op});
        send_word(addr[31:0]);
        send_word(addr[63:32]);
        send_word(data[31:0]);
        send_word(data[63:32]);
    endtask

    task automatic wait_idle(input string tag);
        logic idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            tick();
            idle = exp_aw.size() == 0 && exp_w.size() == 0 && !awvalid && !wvalid &&
                   aw_cnt == b_cnt && !bvalid && nbf_ready;
        end
        if (!idle) check(tag, 64'(idle), 64'd1);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        nbf_v  = 1'b0;
        repeat (3) tick();
        check("rst_ready",   64'(nbf_ready), 64'd0);
        check("rst_valids",  64'({awvalid, wvalid}), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        check("rst_bready",  64'(bready), 64'd0);
        areset = 1'b0;
        tick();
        check("post_rst_ready",  64'(nbf_ready), 64'd1);
        check("post_rst_bready", 64'(bready), 64'd1);
    endtask

    initial begin
        int base, bb, acc;
        areset = 1'b1; nbf_v = 1'b0; nbf_data = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        do_reset();

        // Basic writes of every size, including the issue latency
        send_pkt(8'h03, 64'h0000_0000_8000_0000, 64'h0123_4567_DEAD_BEEF);
        check("lat_valids", 64'({awvalid, wvalid}), 64'b11);
        check("lat_ready",  64'(nbf_ready), 64'd0);
        wait_idle("idle_write8");
        send_pkt(8'h00, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB);
        send_pkt(8'h01, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF);
        send_pkt(8'h02, 64'h0000_0000_8000_0004, 64'h0000_0000_CAFE_F00D);
        wait_idle("idle_small_writes");

        // AW backpressure while W completes immediately
        aw_stall = 20;
        send_pkt(8'h03, 64'h0000_0001_0000_0008, 64'h1111_2222_3333_4444);
        tick();
        check("bp_w_dropped", 64'({awvalid, wvalid, nbf_ready}), 64'b100);
        repeat (5) tick();
        check("bp_aw_held",   64'({awvalid, wvalid, nbf_ready}), 64'b100);
        wait_idle("idle_backpressure");

        // Outstanding limit
        b_hold = 1'b1;
        base   = aw_cnt;
        send_pkt(8'h03, 64'h0000_0000_8000_1000, 64'hA000_0000_0000_0001);
        send_pkt(8'h03, 64'h0000_0000_8000_1008, 64'hA000_0000_0000_0002);
        send_pkt(8'h03, 64'h0000_0000_8000_1010, 64'hA000_0000_0000_0003);
        repeat (8) tick();
        check("throttle_aw_count", 64'(aw_cnt - base), 64'd2);
        check("throttle_hold",     64'(awvalid), 64'd0);
        b_hold = 1'b0;
        bb = b_cnt;
        for (int i = 0; i < 20 && b_cnt == bb; i++) tick();
        check("throttle_aw_after_b", 64'(awvalid), 64'd1);
        wait_idle("idle_throttle");

        // Unknown opcode is dropped
        base = aw_cnt;
        send_pkt(8'h42, 64'h0000_0000_8000_2000, 64'hFFFF_FFFF_FFFF_FFFF);
        check("unk_ready", 64'(nbf_ready), 64'd1);
        repeat (4) tick();
        check("unk_no_aw", 64'(aw_cnt - base), 64'd0);
        send_pkt(8'h01, 64'h0000_0000_8000_0002, 64'h0000_0000_0000_5A5A);
        wait_idle("idle_after_unknown");
        check("unk_next_aw", 64'(aw_cnt - base), 64'd1);

        // Fence with nothing outstanding, then with a write pending
        send_pkt(8'hFE, 64'd0, 64'd0);
        check("fence0_entry", 64'(nbf_ready), 64'd0);
        tick();
        check("fence0_exit", 64'(nbf_ready), 64'd1);
        b_hold = 1'b1;
        send_pkt(8'h03, 64'h0000_0000_8000_3000, 64'h5555_6666_7777_8888);
        send_pkt(8'hFE, 64'd0, 64'd0);
        repeat (6) tick();
        check("fence_stall", 64'(nbf_ready), 64'd0);
        b_hold = 1'b0;
        wait_idle("idle_fence");

        // Finish waits for all B responses, then stops accepting
        b_hold = 1'b1;
        send_pkt(8'h03, 64'h0000_0000_8000_4000, 64'h0000_0000_0000_0011);
        send_pkt(8'h02, 64'h0000_0000_8000_4008, 64'h0000_0000_0000_0022);
        send_pkt(8'hFF, 64'd0, 64'd0);
        repeat (20) tick();
        check("done_early", 64'(done), 64'd0);
        b_hold = 1'b0;
        for (int i = 0; i < 50 && b_cnt != aw_cnt; i++) tick();
        check("finish_b_drained", 64'(aw_cnt - b_cnt), 64'd0);
        check("done_not_yet", 64'(done), 64'd0);
        tick();
        check("done_latency", 64'(done), 64'd1);
        nbf_v = 1'b1;
        acc = 0;
        repeat (10) begin
            tick();
            acc += int'(nbf_acc);
        end
        nbf_v = 1'b0;
        check("done_no_accept", 64'(acc), 64'd0);
        check("done_sticky",    64'(done), 64'd1);

        // Reset mid-packet, then an error response ahead of finish
        do_reset();
        send_word(32'h0000_0003);
        send_word(32'h8000_5000);
        do_reset();
        b_resp_cfg = 2'b10;
        send_pkt(8'h03, 64'h0000_0000_8000_6000, 64'hCAFE_0000_BABE_0000);
        wait_idle("idle_bresp");
        b_resp_cfg = 2'b00;
        check("bresp_err", 64'(err), 64'(EXP_ERR));
        send_pkt(8'hFF, 64'd0, 64'd0);
        repeat (5) tick();
        check("finish_with_err_done", 64'(done), 64'(EXP_DONE));
        check("finish_with_err_err",  64'(err), 64'(EXP_ERR));

        check("aw_scoreboard_empty", 64'(exp_aw.size()), 64'd0);
        check("w_scoreboard_empty",  64'(exp_w.size()), 64'd0);
        check("aw_w_count_match",    64'(aw_cnt), 64'(w_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
